// File: rtl/conv_punct_enc.sv
// conv_punct_enc: rate-1/2 K=7 convolutional encoder (G0/G1 generators) with
// optional 2/3 and 3/4 puncturing. One data bit in per handshake, one coded
// bit out per handshake. A one-bit overflow slot behind the output register
// keeps rate 1/2 bubble-free under continuous out_ready.
// Build option: define CONV_PUNCT_EN to enable rates 2/3 and 3/4. Without it
// the rate input is ignored and every accepted bit emits A then B.
module conv_punct_enc #(
  parameter logic [6:0] G0 = 7'o133,
  parameter logic [6:0] G1 = 7'o171
) (
  input  logic       clk,
  input  logic       phy_tx_arest_n,
  input  logic       start,
  input  logic [1:0] rate,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  logic [5:0] r_state;
  logic       r_out_bit;
  logic       r_out_valid;
  logic       r_out_last;
  logic       r_buf_bit;
  logic       r_buf_valid;
  logic       r_buf_last;

  logic [6:0] w_vec;
  logic       w_a;
  logic       w_b;
  logic       w_accept;
  logic       w_emit_a;
  logic       w_emit_b;
  logic       w_two;
  logic       w_first;

  assign w_vec = {in_bit, r_state};
  assign w_a   = ^(w_vec & G0);
  assign w_b   = ^(w_vec & G1);

`ifdef CONV_PUNCT_EN
  logic [1:0] r_rate;
  logic [1:0] r_phase;
  logic [1:0] w_phase_next;

  // Puncture pattern: which of A/B survive at the current phase, and the next phase.
  always_comb begin
    w_emit_a     = 1'b1;
    w_emit_b     = 1'b1;
    w_phase_next = 2'd0;
    case (r_rate)
      2'd1: begin
        w_emit_b     = (r_phase == 2'd0);
        w_phase_next = (r_phase == 2'd0) ? 2'd1 : 2'd0;
      end
      2'd2: begin
        w_emit_a     = (r_phase != 2'd2);
        w_emit_b     = (r_phase != 2'd1);
        w_phase_next = (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
      end
      default: begin
      end
    endcase
  end

  // Rate is latched on start (3 folds to 1/2); phase advances once per accepted bit.
  always_ff @(posedge clk or negedge phy_tx_arest_n) begin
    if (!phy_tx_arest_n) begin
      r_rate  <= 2'd0;
      r_phase <= 2'd0;
    end else if (start) begin
      r_rate  <= (rate == 2'd3) ? 2'd0 : rate;
      r_phase <= 2'd0;
    end else if (w_accept) begin
      r_phase <= w_phase_next;
    end
  end
`else
  logic w_unused_rate;
  assign w_unused_rate = ^rate;
  assign w_emit_a      = 1'b1;
  assign w_emit_b      = 1'b1;
`endif

  // When both bits survive, A goes out first and B waits in the overflow slot.
  assign w_two   = w_emit_a && w_emit_b;
  assign w_first = w_emit_a ? w_a : w_b;

  // Accept only when the result fits: empty, or one bit held that leaves this cycle.
  assign in_ready = !start && (!r_out_valid || (!r_buf_valid && out_ready));
  assign w_accept = in_valid && in_ready;

  // Encoder shift register plus output/overflow slots; start aborts everything.
  always_ff @(posedge clk or negedge phy_tx_arest_n) begin
    if (!phy_tx_arest_n) begin
      r_state     <= 6'd0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_buf_bit   <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_last  <= 1'b0;
    end else if (start) begin
      r_state     <= 6'd0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_last  <= 1'b0;
    end else if (w_accept) begin
      r_state     <= {in_bit, r_state[5:1]};
      r_out_bit   <= w_first;
      r_out_valid <= 1'b1;
      r_out_last  <= in_last && !w_two;
      r_buf_bit   <= w_b;
      r_buf_valid <= w_two;
      r_buf_last  <= in_last && w_two;
    end else if (r_out_valid && out_ready) begin
      r_out_bit   <= r_buf_bit;
      r_out_valid <= r_buf_valid;
      r_out_last  <= r_buf_last;
      r_buf_valid <= 1'b0;
      r_buf_last  <= 1'b0;
    end
  end

  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_out_valid || r_buf_valid;

endmodule

// File: tb/tb_conv_punct_enc.sv
// Bench for conv_punct_enc: a queue-based model of the coded stream checked
// against the DUT every cycle, plus literal coded sequences for each scenario.
module tb_conv_punct_enc;

  localparam logic [6:0] P0 = 7'o133;
  localparam logic [6:0] P1 = 7'o171;

  logic       clk = 1'b0;
  logic       phy_tx_arest_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rate = 2'd0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  int total = 0;
  int bad = 0;

  // model state
  logic [1:0] mq[$];      // pending coded bits {bit, last}, head = on the output
  logic [1:0] m_log[$];   // every bit the model produced since the last clear
  logic [1:0] d_log[$];   // every bit the DUT handed over since the last clear
  bit         past[0:5];  // past[0] = previous input, past[5] = six back
  int         m_cnt = 0;
  int         m_rate = 0;
  bit         m_acc = 1'b0;
  bit         toggle_mode = 1'b0;
  bit         ma, mb, macc;
  logic [1:0] mpat;

  conv_punct_enc dut (
    .clk(clk), .phy_tx_arest_n(phy_tx_arest_n), .start(start), .rate(rate),
    .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int eff_rate(logic [1:0] r);
`ifdef CONV_PUNCT_EN
    return (r == 2'd3) ? 0 : int'(r);
`else
    return 0;
`endif
  endfunction

  // tap definition: coded bit = XOR of current and past inputs selected by g
  function automatic bit code_bit(logic [6:0] g, bit cur);
    bit x;
    x = g[6] & cur;
    for (int k = 1; k <= 6; k++) x = x ^ (g[6-k] & past[k-1]);
    return x;
  endfunction

  // {keep A, keep B} for the idx-th input since start
  function automatic logic [1:0] pattern(int r, int idx);
    if (r == 1) return (idx % 2 == 0) ? 2'b11 : 2'b10;
    if (r == 2) begin
      if (idx % 3 == 0) return 2'b11;
      if (idx % 3 == 1) return 2'b10;
      return 2'b01;
    end
    return 2'b11;
  endfunction

  function automatic bit exp_ready();
    return !start && (mq.size() == 0 || (mq.size() == 1 && out_ready));
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // model update on the clock edge
  always @(posedge clk or negedge phy_tx_arest_n) begin
    if (!phy_tx_arest_n) begin
      mq.delete();
      for (int k = 0; k < 6; k++) past[k] = 1'b0;
      m_cnt = 0;
      m_rate = 0;
      m_acc = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (start) begin
        mq.delete();
        for (int k = 0; k < 6; k++) past[k] = 1'b0;
        m_cnt = 0;
        m_rate = eff_rate(rate);
      end else begin
        macc = in_valid && exp_ready();
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (macc) begin
          ma = code_bit(P0, in_bit);
          mb = code_bit(P1, in_bit);
          mpat = pattern(m_rate, m_cnt);
          if (mpat == 2'b11) begin
            mq.push_back({ma, 1'b0});     m_log.push_back({ma, 1'b0});
            mq.push_back({mb, in_last});  m_log.push_back({mb, in_last});
          end else if (mpat == 2'b10) begin
            mq.push_back({ma, in_last});  m_log.push_back({ma, in_last});
          end else begin
            mq.push_back({mb, in_last});  m_log.push_back({mb, in_last});
          end
          for (int k = 5; k > 0; k--) past[k] = past[k-1];
          past[0] = in_bit;
          m_cnt++;
          m_acc = 1'b1;
        end
      end
    end
  end

  // per-cycle comparison on the falling edge
  always @(negedge clk) begin
    chk("in_ready", in_ready, exp_ready());
    chk("out_valid", out_valid, mq.size() > 0);
    chk("busy", busy, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_bit", out_bit, mq[0][1]);
      chk("out_last", out_last, mq[0][0]);
    end
    if (phy_tx_arest_n && out_valid && out_ready) d_log.push_back({out_bit, out_last});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_mode) out_ready = !out_ready;
  endtask

  task automatic send(bit b, bit last);
    bit got;
    got = 1'b0;
    in_bit = b;
    in_valid = 1'b1;
    in_last = last;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (m_acc) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (mq.size() == 0) break;
      tick();
    end
    if (mq.size() != 0) chk("drain_timeout", mq.size(), 0);
  endtask

  task automatic clear_logs();
    m_log.delete();
    d_log.delete();
  endtask

  task automatic do_start(logic [1:0] r);
    start = 1'b1;
    rate = r;
    tick();
    start = 1'b0;
    clear_logs();
  endtask

  task automatic check_stream(string name, bit use_model, int n, logic [31:0] eb, logic [31:0] el);
    logic [31:0] vb, vl;
    logic [1:0] e;
    int sz;
    vb = 0;
    vl = 0;
    sz = use_model ? m_log.size() : d_log.size();
    chk({name, "_len"}, sz, n);
    for (int i = 0; i < sz; i++) begin
      e = use_model ? m_log[i] : d_log[i];
      vb = (vb << 1) | {31'd0, e[1]};
      vl = (vl << 1) | {31'd0, e[0]};
    end
    chk({name, "_bits"}, vb, eb);
    chk({name, "_last"}, vl, el);
  endtask

  task automatic both_streams(string name, int n, logic [31:0] eb, logic [31:0] el);
    check_stream({name, "_model"}, 1'b1, n, eb, el);
    check_stream({name, "_dut"}, 1'b0, n, eb, el);
  endtask

  task automatic send_impulse7();
    send(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send(1'b0, i == 5);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    phy_tx_arest_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // rate 1/2 impulse response, first bit visible the cycle after accept
    do_start(2'd0);
    send(1'b1, 1'b0);
    chk("latency_valid", out_valid, 1);
    chk("latency_bit", out_bit, 1);
    for (int i = 0; i < 6; i++) send(1'b0, i == 5);
    drain();
    both_streams("r12", 14, 32'b11011111001011, 32'b00000000000001);

`ifdef CONV_PUNCT_EN
    // rate 3/4
    do_start(2'd2);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b1);
    drain();
    both_streams("r34", 4, 32'b1101, 32'b0001);

    // rate 2/3, then continuing phase and state
    do_start(2'd1);
    send(1'b1, 1'b0); send(1'b0, 1'b1);
    drain();
    both_streams("r23a", 3, 32'b110, 32'b001);
    clear_logs();
    send(1'b0, 1'b0); send(1'b0, 1'b1);
    drain();
    both_streams("r23b", 3, 32'b111, 32'b001);
`else
    // rate input is ignored: asking for 3/4 still yields rate 1/2
    do_start(2'd2);
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b1);
    drain();
    both_streams("rate_ignored", 6, 32'b110111, 32'b000001);
`endif

    // backpressure with out_ready toggling
    do_start(2'd0);
    toggle_mode = 1'b1;
    send_impulse7();
    drain();
    toggle_mode = 1'b0;
    out_ready = 1'b1;
    both_streams("bp", 14, 32'b11011111001011, 32'b00000000000001);

    // start with two bits pending and a coincident valid input
    do_start(2'd0);
    out_ready = 1'b0;
    send(1'b1, 1'b0);
    tick();
    start = 1'b1;
    rate = 2'd2;
    in_valid = 1'b1;
    in_bit = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    out_ready = 1'b1;
    clear_logs();
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b1);
    drain();
`ifdef CONV_PUNCT_EN
    both_streams("restart", 4, 32'b1101, 32'b0001);
`else
    both_streams("restart", 6, 32'b110111, 32'b000001);
`endif

    // asynchronous reset mid-frame
    do_start(2'd2);
    out_ready = 1'b0;
    send(1'b1, 1'b0);
    #2;
    phy_tx_arest_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_bit", out_bit, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    tick();
    phy_tx_arest_n = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);
    clear_logs();
    send_impulse7();
    drain();
    both_streams("post_rst_r12", 14, 32'b11011111001011, 32'b00000000000001);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
